// File: rtl/plab3_mem_secure_mem_filter.sv
// Memory-side security filter between a blocking L1 cache and memory.
// It denies non-secure accesses to a protected window and checks the domain tag on each response.
module plab3_mem_secure_mem_filter #(
    parameter int unsigned    p_opaque_nbits = 8,
    parameter int unsigned    abw            = 32,
    parameter int unsigned    clw            = 128,
    parameter logic [abw-1:0] p_sec_base     = 32'h0000_8000,
    parameter logic [abw-1:0] p_sec_bound    = 32'h0000_FFFF,
    localparam int unsigned   LenNbits       = $clog2(clw / 8),
    localparam int unsigned   RqNbits        = 3 + p_opaque_nbits + abw + LenNbits + clw,
    localparam int unsigned   RsNbits        = 3 + p_opaque_nbits + 2 + LenNbits + clw
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [RqNbits-1:0] memreq_msg,
    input  logic               memreq_val,
    output logic               memreq_rdy,
    input  logic               memreq_domain,

    output logic [RsNbits-1:0] memresp_msg,
    output logic               memresp_val,
    input  logic               memresp_rdy,
    output logic               memresp_domain,
    output logic               fail,

    output logic [RqNbits-1:0] mem_req_msg,
    output logic               mem_req_val,
    input  logic               mem_req_rdy,
    output logic               mem_req_domain,

    input  logic [RsNbits-1:0] mem_resp_msg,
    input  logic               mem_resp_val,
    output logic               mem_resp_rdy,
    input  logic               mem_resp_domain,

    output logic [7:0]         viol_count
);

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StWait,
        StResp
    } state_e;

    // Request field positions (MSB first: type, opaque, addr, len, data)
    localparam int unsigned ReqAddrLsb = clw + LenNbits;
    localparam int unsigned ReqOpqLsb  = ReqAddrLsb + abw;

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_out_of_reset;

    logic [RqNbits-1:0]   r_req_msg;
    logic [RqNbits-1:0]   w_req_msg_next;
    logic                 r_req_domain;
    logic                 w_req_domain_next;

    logic [RsNbits-1:0]   r_resp_msg;
    logic [RsNbits-1:0]   w_resp_msg_next;
    logic                 r_resp_domain;
    logic                 w_resp_domain_next;
    logic                 r_fail;
    logic                 w_fail_next;

    logic [7:0]           r_viol_count;
    logic [7:0]           w_viol_count_next;

    logic [2:0]                w_req_type;
    logic [p_opaque_nbits-1:0] w_req_opaque;
    logic [abw-1:0]            w_req_addr;
    logic                      w_in_window;
    logic                      w_deny;
    logic                      w_req_fire;
    logic                      w_fwd_fire;
    logic                      w_mem_resp_fire;
    logic                      w_resp_fire;
    logic                      w_domain_mismatch;
    logic [RsNbits-1:0]        w_deny_resp;
    logic [RsNbits-1:0]        w_mem_resp_filt;

    assign w_req_type   = memreq_msg[RqNbits-1 -: 3];
    assign w_req_opaque = memreq_msg[ReqOpqLsb +: p_opaque_nbits];
    assign w_req_addr   = memreq_msg[ReqAddrLsb +: abw];

    assign w_in_window = (w_req_addr >= p_sec_base) && (w_req_addr <= p_sec_bound);
    assign w_deny      = !memreq_domain && w_in_window;

    assign w_req_fire      = memreq_rdy && memreq_val;
    assign w_fwd_fire      = mem_req_val && mem_req_rdy;
    assign w_mem_resp_fire = mem_resp_rdy && mem_resp_val;
    assign w_resp_fire     = memresp_val && memresp_rdy;

    // Denial response: request type and opaque kept, test/len/data all zero
    assign w_deny_resp = {w_req_type, w_req_opaque, 2'b00, {LenNbits{1'b0}}, {clw{1'b0}}};

    // A response tagged with the wrong domain keeps its header but loses its data
    assign w_domain_mismatch = (mem_resp_domain != r_req_domain);
    assign w_mem_resp_filt   = w_domain_mismatch ? {mem_resp_msg[RsNbits-1:clw], {clw{1'b0}}}
                                                 : mem_resp_msg;

    always_comb begin
        w_state_next       = r_state;
        w_req_msg_next     = r_req_msg;
        w_req_domain_next  = r_req_domain;
        w_resp_msg_next    = r_resp_msg;
        w_resp_domain_next = r_resp_domain;
        w_fail_next        = r_fail;
        w_viol_count_next  = r_viol_count;

        case (r_state)
            StIdle: begin
                if (w_req_fire) begin
                    w_req_msg_next    = memreq_msg;
                    w_req_domain_next = memreq_domain;
                    if (w_deny) begin
                        w_resp_msg_next    = w_deny_resp;
                        w_resp_domain_next = memreq_domain;
                        w_fail_next        = 1'b1;
                        if (r_viol_count != 8'hFF) begin
                            w_viol_count_next = r_viol_count + 8'd1;
                        end
                        w_state_next = StResp;
                    end else begin
                        w_state_next = StFwd;
                    end
                end
            end
            StFwd: begin
                if (w_fwd_fire) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_mem_resp_fire) begin
                    w_resp_msg_next    = w_mem_resp_filt;
                    w_resp_domain_next = r_req_domain;
                    w_fail_next        = w_domain_mismatch;
                    w_state_next       = StResp;
                end
            end
            StResp: begin
                if (w_resp_fire) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= StIdle;
            r_out_of_reset <= 1'b0;
            r_req_msg      <= '0;
            r_req_domain   <= 1'b0;
            r_resp_msg     <= '0;
            r_resp_domain  <= 1'b0;
            r_fail         <= 1'b0;
            r_viol_count   <= 8'd0;
        end else begin
            r_state        <= w_state_next;
            r_out_of_reset <= 1'b1;
            r_req_msg      <= w_req_msg_next;
            r_req_domain   <= w_req_domain_next;
            r_resp_msg     <= w_resp_msg_next;
            r_resp_domain  <= w_resp_domain_next;
            r_fail         <= w_fail_next;
            r_viol_count   <= w_viol_count_next;
        end
    end

    // Handshake outputs decode registered state only; memreq_rdy also waits one edge past reset
    assign memreq_rdy   = (r_state == StIdle) && r_out_of_reset;
    assign mem_req_val  = (r_state == StFwd);
    assign mem_resp_rdy = (r_state == StWait);
    assign memresp_val  = (r_state == StResp);

    assign mem_req_msg    = r_req_msg;
    assign mem_req_domain = r_req_domain;
    assign memresp_msg    = r_resp_msg;
    assign memresp_domain = r_resp_domain;
    assign fail           = r_fail;
    assign viol_count     = r_viol_count;

endmodule
